serial_tx: RTL and testbench
============================

# serial_tx

Frame-based serial transmitter, the sending end of the team's D-flip-flop serial link. Accepts a parallel word over a valid/ready handshake, holds it in a shadow register, and shifts it out on a single line as start bit, data bits LSB first, stop bit, with each bit held for a fixed number of clock cycles. Sits between the lab's parallel datapath, such as switch inputs or counter outputs, and the serial line that feeds the shift-register receiver.

## Interface
Parameters:
- WIDTH, 8, data bits per frame (≥1)
- CLKS_PER_BIT, 4, clock cycles each bit is held on the line (≥1)

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset; one clock domain only
- data_in  input  WIDTH  word to send, sampled only at accept
- load_valid  input  1  sender has a word on data_in
- load_ready  output  1  transmitter idle and able to accept
- tx_out  output  1  serial line, idles high
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse when a frame completes

## Operation
- States: IDLE, START, DATA, STOP.
- load_ready = (state == IDLE). busy = (state != IDLE).
- Accept happens at a rising edge where load_valid && load_ready:
  - data_in is latched into the shift register.
  - State goes to START; bit counter and cycle counter are cleared.
- START: tx_out = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx_out = shift_reg[0], held CLKS_PER_BIT cycles.
  - The register shifts right at the end of each bit.
  - After WIDTH bits, go to STOP.
- STOP: tx_out = 1 for CLKS_PER_BIT cycles, then go to IDLE with done = 1 for exactly that first IDLE cycle.
- tx_out is a registered output and never glitches.
- Changes on data_in or load_valid while busy are ignored.
- Bit counter width is $clog2(WIDTH+1). Cycle counter width is max(1, $clog2(CLKS_PER_BIT)).
  - The cycle counter wraps to 0 at CLKS_PER_BIT-1.
  - CLKS_PER_BIT = 1 is legal: every cycle is one bit.
- Reset (async assert, at any time including mid-frame):
  - state = IDLE, tx_out = 1, load_ready = 1, busy = 0, done = 0, shift register = 0, counters = 0.
  - A frame cut off by reset is abandoned, not resumed.
- Release of rst_n is synchronous to clk. The first accept can happen at the first rising edge after release.

## Timing
- Accept at edge E0: tx_out falls to 0 right after E0.
- Data bit i occupies cycles [(1+i)·C, (2+i)·C) after E0, where C = CLKS_PER_BIT.
- Stop bit occupies [(WIDTH+1)·C, (WIDTH+2)·C).
- State returns to IDLE and done pulses in cycle (WIDTH+2)·C after E0. load_ready is high in that same cycle.
- Back-to-back: if load_valid is held, the next accept is at the edge ending the done cycle. The line therefore stays high for C+1 cycles between frames.
- Frame period under continuous valid is (WIDTH+2)·C+1 cycles.

## Structure
- Shared package serial_pkg holds:
  - the state enum (IDLE=0, START=1, DATA=2, STOP=3)
  - START_BIT = 1'b0, STOP_BIT = 1'b1, IDLE_LEVEL = 1'b1
  - the receiver imports the same package.
- One sub-module, bit_timer (parameter CLKS_PER_BIT):
  - cycle counter that produces a bit_end pulse on the last cycle of each bit
  - cleared by a synchronous clear input at accept
  - uses the same clk/rst_n.
- The top level holds the FSM, the shift register and the bit counter.

## Test plan
- Reset: assert rst_n = 0 mid-DATA of frame 8'hFF → immediately tx_out = 1, busy = 0, load_ready = 1, done = 0. After release, send 8'h01 → a clean full frame, no remnant of the aborted frame.
- Single frame, WIDTH=8, C=4, data 8'hA5 → tx_out sequence 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles. done pulses exactly once, 40 cycles after accept.
- Back-to-back, load_valid held high, data 8'h3C then 8'hC3 → second accept exactly 41 cycles after the first. Both frames are correct, and the line is high for 5 cycles between them.
- Data stability: change data_in to 8'h00 and pulse load_valid during a frame of 8'h5A → transmitted bits are those of 8'h5A, and no extra accept occurs.
- Minimum timing, C=1, WIDTH=4, data 4'b1001 → tx_out = 0,1,0,0,1,1 on consecutive cycles. done appears 6 cycles after accept.
- Idle behaviour: hold load_valid = 0 for 100 cycles after reset → tx_out stays 1, busy stays 0, and done never asserts.

Source files
------------

// File: rtl/serial_pkg.sv
// ============================================================================
// Module      : serial_pkg
// Description : Shared types and line levels for the serial link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } serial_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_tx_if.sv
// ============================================================================
// Module      : serial_tx_if
// Description : Parallel load handshake between a word source and serial_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready
    );
endinterface

`default_nettype wire

// File: rtl/serial_tx_bit_timer.sv
// ============================================================================
// Module      : bit_timer
// Description : Per-bit cycle counter; flags the last cycle of every bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int              CW     = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]   c_last = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    assign bit_end = enable && (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= bit_end ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_tx.sv
// ============================================================================
// Module      : serial_tx
// Description : Frame transmitter: start bit, WIDTH data bits LSB first, stop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_tx_if.slave  bus,
    output logic        tx_out,
    output logic        busy,
    output logic        done
);

    localparam int            BW         = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] c_last_bit = BW'(WIDTH - 1);

    serial_state_e    r_state,   w_state_nxt;
    logic [WIDTH-1:0] r_shift,   w_shift_nxt;
    logic [BW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic             r_tx,      w_tx_nxt;
    logic             r_done,    w_done_nxt;
    logic             w_accept;
    logic             w_bit_end;

    assign bus.load_ready = (r_state == IDLE);
    assign w_accept       = bus.load_valid && (r_state == IDLE);

    assign tx_out = r_tx;
    assign done   = r_done;
    assign busy   = (r_state != IDLE);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_accept),
        .enable  (r_state != IDLE),
        .bit_end (w_bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= IDLE_LEVEL;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_tx      <= w_tx_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_done_nxt    = 1'b0;
        w_tx_nxt      = IDLE_LEVEL;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = START;
                    w_shift_nxt   = bus.data_in;
                    w_bit_cnt_nxt = '0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == c_last_bit) begin
                        w_state_nxt   = STOP;
                        w_bit_cnt_nxt = '0;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Line level is derived from the next state so tx_out comes straight off a flop.
        case (w_state_nxt)
            START:   w_tx_nxt = START_BIT;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            STOP:    w_tx_nxt = STOP_BIT;
            default: w_tx_nxt = IDLE_LEVEL;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_tx.sv
// ============================================================================
// Module      : tb_serial_tx
// Description : Directed self-checking bench for serial_tx (8x4 and 4x1 builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    serial_tx_if #(.WIDTH(8)) big_if ();
    serial_tx_if #(.WIDTH(4)) min_if ();

    logic big_tx, big_busy, big_done;
    logic min_tx, min_busy, min_done;

    int   n_asserts = 0;
    int   n_fail    = 0;
    logic exp_q[$];
    time  accept_t  = 0;

    always #5 clk = ~clk;

    serial_tx #(
        .WIDTH        (8),
        .CLKS_PER_BIT (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (big_if.slave),
        .tx_out (big_tx),
        .busy   (big_busy),
        .done   (big_done)
    );

    serial_tx #(
        .WIDTH        (4),
        .CLKS_PER_BIT (1)
    ) dut_min (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (min_if.slave),
        .tx_out (min_tx),
        .busy   (min_busy),
        .done   (min_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {tx, busy, ready, done} of the selected instance
    function automatic logic [3:0] outs(input bit m);
        return m ? {min_tx, min_busy, min_if.load_ready, min_done}
                 : {big_tx, big_busy, big_if.load_ready, big_done};
    endfunction

    task automatic drive(input bit m, input logic [7:0] word, input logic valid);
        if (m) begin
            min_if.data_in    = word[3:0];
            min_if.load_valid = valid;
        end else begin
            big_if.data_in    = word;
            big_if.load_valid = valid;
        end
    endtask

    // Called at a negedge with the selected instance idle.
    task automatic run_frame(input bit m, input logic [7:0] word, input bit hold_valid,
                             input logic [7:0] next_word, input bit disturb);
        int          w;
        int          c;
        logic [3:0]  o;
        logic        e;
        w = m ? 4 : 8;
        c = m ? 1 : 4;
        o = outs(m);
        chk("ready_before_accept", o[1], 1'b1);
        drive(m, word, 1'b1);
        @(posedge clk);
        accept_t = $time;
        for (int j = 0; j < c; j++) exp_q.push_back(1'b0);
        for (int i = 0; i < w; i++)
            for (int j = 0; j < c; j++) exp_q.push_back(word[i]);
        for (int j = 0; j < c; j++) exp_q.push_back(1'b1);
        for (int k = 0; k < (w + 2) * c; k++) begin
            @(negedge clk);
            if (k == 0) begin
                if (hold_valid) drive(m, next_word, 1'b1);
                else            drive(m, word, 1'b0);
            end
            if (disturb && k == 10) drive(m, 8'h00, 1'b1);
            if (disturb && k == 12) drive(m, 8'h00, 1'b0);
            o = outs(m);
            e = exp_q.pop_front();
            chk($sformatf("tx_bit[%0d] word=%0h", k, word), o[3], e);
            chk($sformatf("done_low[%0d]", k), o[0], 1'b0);
            chk($sformatf("busy_high[%0d]", k), o[2], 1'b1);
        end
        @(negedge clk);
        o = outs(m);
        chk("done_pulse", o[0], 1'b1);
        chk("ready_in_done_cycle", o[1], 1'b1);
        chk("busy_low_in_done_cycle", o[2], 1'b0);
        chk("tx_idle_in_done_cycle", o[3], 1'b1);
    endtask

    initial begin
        time        t_first;
        logic [3:0] o;

        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            o = outs(m[0]);
            chk("reset_tx", o[3], 1'b1);
            chk("reset_busy", o[2], 1'b0);
            chk("reset_ready", o[1], 1'b1);
            chk("reset_done", o[0], 1'b0);
        end
        rst_n = 1'b1;

        // Idle with no valid
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            o = outs(1'b0);
            chk("idle_tx", o[3], 1'b1);
            chk("idle_busy", o[2], 1'b0);
            chk("idle_done", o[0], 1'b0);
        end

        // Single frame
        run_frame(1'b0, 8'hA5, 1'b0, 8'h00, 1'b0);

        // Back-to-back with valid held
        run_frame(1'b0, 8'h3C, 1'b1, 8'hC3, 1'b0);
        t_first = accept_t;
        run_frame(1'b0, 8'hC3, 1'b0, 8'h00, 1'b0);
        chk("b2b_accept_gap", 32'((accept_t - t_first) / 10), 32'd41);

        // Input changes while busy are ignored
        @(negedge clk);
        run_frame(1'b0, 8'h5A, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            o = outs(1'b0);
            chk("no_extra_accept_busy", o[2], 1'b0);
            chk("no_extra_accept_tx", o[3], 1'b1);
        end

        // Minimum timing build
        run_frame(1'b1, 8'h09, 1'b0, 8'h00, 1'b0);

        // Reset mid-frame
        @(negedge clk);
        drive(1'b0, 8'hFF, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 8'hFF, 1'b0);
        repeat (14) @(negedge clk);
        o = outs(1'b0);
        chk("pre_reset_busy", o[2], 1'b1);
        chk("pre_reset_tx", o[3], 1'b1);
        rst_n = 1'b0;
        #1;
        o = outs(1'b0);
        chk("midreset_tx", o[3], 1'b1);
        chk("midreset_busy", o[2], 1'b0);
        chk("midreset_ready", o[1], 1'b1);
        chk("midreset_done", o[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(1'b0, 8'h01, 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
